// File: rtl/wb_interconnect_np_if.sv
// Bus bundle for the single-master, N-slave Wishbone classic interconnect.
// The "slave" modport is the interconnect's view (it is the slave of M0 and
// drives the per-slave request lines). The "master" modport is the
// surrounding system's view: M0 plus the attached peripherals.
interface wb_interconnect_np_if #(
  parameter int NUM_SLAVES = 4,
  parameter int SLV_AW     = 9
);
  // M0 side
  logic [31:0]              m0_wb_dat_i;
  logic [31:0]              m0_wb_adr_i;
  logic [3:0]               m0_wb_sel_i;
  logic                     m0_wb_we_i;
  logic                     m0_wb_cyc_i;
  logic                     m0_wb_stb_i;
  logic [31:0]              m0_wb_dat_o;
  logic                     m0_wb_ack_o;
  logic                     m0_wb_err_o;
  // peripheral side
  logic [32*NUM_SLAVES-1:0] s_wb_dat_i;
  logic [NUM_SLAVES-1:0]    s_wb_ack_i;
  logic [31:0]              s_wb_dat_o;
  logic [SLV_AW-1:0]        s_wb_adr_o;
  logic [3:0]               s_wb_sel_o;
  logic                     s_wb_we_o;
  logic [NUM_SLAVES-1:0]    s_wb_cyc_o;
  logic [NUM_SLAVES-1:0]    s_wb_stb_o;

  modport slave (
    input  m0_wb_dat_i, m0_wb_adr_i, m0_wb_sel_i, m0_wb_we_i, m0_wb_cyc_i, m0_wb_stb_i,
    output m0_wb_dat_o, m0_wb_ack_o, m0_wb_err_o,
    input  s_wb_dat_i, s_wb_ack_i,
    output s_wb_dat_o, s_wb_adr_o, s_wb_sel_o, s_wb_we_o, s_wb_cyc_o, s_wb_stb_o
  );

  modport master (
    output m0_wb_dat_i, m0_wb_adr_i, m0_wb_sel_i, m0_wb_we_i, m0_wb_cyc_i, m0_wb_stb_i,
    input  m0_wb_dat_o, m0_wb_ack_o, m0_wb_err_o,
    output s_wb_dat_i, s_wb_ack_i,
    input  s_wb_dat_o, s_wb_adr_o, s_wb_sel_o, s_wb_we_o, s_wb_cyc_o, s_wb_stb_o
  );
endinterface

// File: rtl/wb_interconnect_np.sv
// Single-master, N-slave Wishbone classic interconnect.
// A master request is registered, routed to the slave chosen by an address
// field and held until that slave acks, the master aborts, or the wait
// budget runs out. The master sees a registered one-cycle ack or err.
// Unmapped slave indices and timeouts both answer with err and zero data.
module wb_interconnect_np #(
  parameter int NUM_SLAVES = 4,
  parameter int SEL_LSB    = 12,
  parameter int SEL_W      = 2,
  parameter int SLV_AW     = 9,
  parameter int TIMEOUT    = 255
) (
  input logic                clk_i,
  input logic                rst,
  wb_interconnect_np_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Counter counts completed REQ cycles; terminal value is TIMEOUT-1 so the
  // error fires at the edge that ends the TIMEOUT-th wait cycle.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  state_t                state_r, state_s;
  logic [SEL_W-1:0]      idx_r, idx_s;
  logic [CNT_W-1:0]      cnt_r, cnt_s;
  logic [31:0]           m0_dat_r, m0_dat_s;
  logic                  m0_ack_r, m0_ack_s;
  logic                  m0_err_r, m0_err_s;
  logic [31:0]           s_dat_r, s_dat_s;
  logic [SLV_AW-1:0]     s_adr_r, s_adr_s;
  logic [3:0]            s_sel_r, s_sel_s;
  logic                  s_we_r, s_we_s;
  logic [NUM_SLAVES-1:0] s_hot_r, s_hot_s;

  logic [SEL_W-1:0]      req_idx_s;
  logic                  req_mapped_s;
  logic [NUM_SLAVES-1:0] req_hot_s;
  logic                  sel_ack_s;
  logic [31:0]           sel_dat_s;
  logic                  unused_adr_s;

  assign req_idx_s    = bus.m0_wb_adr_i[SEL_LSB +: SEL_W];
  assign req_mapped_s = (32'(req_idx_s) < 32'(NUM_SLAVES));
  // Address bits outside the word-address and select fields are don't-care.
  assign unused_adr_s = ^bus.m0_wb_adr_i;

  // Decode the incoming index to one-hot and mux the selected slave's ack/data.
  always_comb begin
    req_hot_s = {NUM_SLAVES{1'b0}};
    sel_ack_s = 1'b0;
    sel_dat_s = 32'h0000_0000;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      req_hot_s[k] = (req_idx_s == SEL_W'(k));
      sel_ack_s    = (idx_r == SEL_W'(k)) ? bus.s_wb_ack_i[k] : sel_ack_s;
      sel_dat_s    = (idx_r == SEL_W'(k)) ? bus.s_wb_dat_i[32*k +: 32] : sel_dat_s;
    end
  end

  // Next-state and next-output logic; slave request lines are zero unless in REQ.
  always_comb begin
    state_s  = state_r;
    idx_s    = idx_r;
    cnt_s    = {CNT_W{1'b0}};
    m0_dat_s = 32'h0000_0000;
    m0_ack_s = 1'b0;
    m0_err_s = 1'b0;
    s_dat_s  = 32'h0000_0000;
    s_adr_s  = {SLV_AW{1'b0}};
    s_sel_s  = 4'h0;
    s_we_s   = 1'b0;
    s_hot_s  = {NUM_SLAVES{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (bus.m0_wb_cyc_i && bus.m0_wb_stb_i) begin
          idx_s = req_idx_s;
          if (req_mapped_s) begin
            state_s = ST_REQ;
            s_dat_s = bus.m0_wb_dat_i;
            s_adr_s = bus.m0_wb_adr_i[SLV_AW+1:2];
            s_sel_s = bus.m0_wb_sel_i;
            s_we_s  = bus.m0_wb_we_i;
            s_hot_s = req_hot_s;
          end else begin
            state_s  = ST_RESP;
            m0_err_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (!bus.m0_wb_cyc_i) begin
          // master abort: release the slave silently
          state_s = ST_IDLE;
        end else if (sel_ack_s) begin
          // an ack on the terminal count still wins over the timeout
          state_s  = ST_RESP;
          m0_ack_s = 1'b1;
          m0_dat_s = sel_dat_s;
        end else if ((TIMEOUT > 0) && (cnt_r == CNT_LAST)) begin
          state_s  = ST_RESP;
          m0_err_s = 1'b1;
        end else begin
          state_s = ST_REQ;
          cnt_s   = cnt_r + CNT_W'(1);
          s_dat_s = s_dat_r;
          s_adr_s = s_adr_r;
          s_sel_s = s_sel_r;
          s_we_s  = s_we_r;
          s_hot_s = s_hot_r;
        end
      end
      ST_RESP: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; synchronous reset clears everything.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      idx_r    <= {SEL_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      m0_dat_r <= 32'h0000_0000;
      m0_ack_r <= 1'b0;
      m0_err_r <= 1'b0;
      s_dat_r  <= 32'h0000_0000;
      s_adr_r  <= {SLV_AW{1'b0}};
      s_sel_r  <= 4'h0;
      s_we_r   <= 1'b0;
      s_hot_r  <= {NUM_SLAVES{1'b0}};
    end else begin
      state_r  <= state_s;
      idx_r    <= idx_s;
      cnt_r    <= cnt_s;
      m0_dat_r <= m0_dat_s;
      m0_ack_r <= m0_ack_s;
      m0_err_r <= m0_err_s;
      s_dat_r  <= s_dat_s;
      s_adr_r  <= s_adr_s;
      s_sel_r  <= s_sel_s;
      s_we_r   <= s_we_s;
      s_hot_r  <= s_hot_s;
    end
  end

  assign bus.m0_wb_dat_o = m0_dat_r;
  assign bus.m0_wb_ack_o = m0_ack_r;
  assign bus.m0_wb_err_o = m0_err_r;
  assign bus.s_wb_dat_o  = s_dat_r;
  assign bus.s_wb_adr_o  = s_adr_r;
  assign bus.s_wb_sel_o  = s_sel_r;
  assign bus.s_wb_we_o   = s_we_r;
  assign bus.s_wb_cyc_o  = s_hot_r;
  assign bus.s_wb_stb_o  = s_hot_r;

endmodule

// File: tb/tb_wb_interconnect_np.sv
// Bench for wb_interconnect_np: two instances (4 slaves and 3 slaves, both
// with an 8-cycle timeout) share one master and one set of slave responses.
// A transaction-level model predicts every output each cycle; directed
// sequences add hand-computed expectations.
module tb_wb_interconnect_np;

  logic         clk_i = 1'b0;
  logic         rst   = 1'b1;
  logic [31:0]  m_dat = 32'h0, m_adr = 32'h0;
  logic [3:0]   m_sel = 4'h0;
  logic         m_we = 1'b0, m_cyc = 1'b0, m_stb = 1'b0;
  logic [127:0] s_dat = 128'h0;
  logic [3:0]   s_ack = 4'h0;
  int           total = 0;
  int           bad   = 0;
  logic         chk_en = 1'b0;

  always #5 clk_i = ~clk_i;

  wb_interconnect_np_if #(.NUM_SLAVES(4), .SLV_AW(9)) bus_a ();
  wb_interconnect_np_if #(.NUM_SLAVES(3), .SLV_AW(9)) bus_b ();

  assign bus_a.m0_wb_dat_i = m_dat;  assign bus_b.m0_wb_dat_i = m_dat;
  assign bus_a.m0_wb_adr_i = m_adr;  assign bus_b.m0_wb_adr_i = m_adr;
  assign bus_a.m0_wb_sel_i = m_sel;  assign bus_b.m0_wb_sel_i = m_sel;
  assign bus_a.m0_wb_we_i  = m_we;   assign bus_b.m0_wb_we_i  = m_we;
  assign bus_a.m0_wb_cyc_i = m_cyc;  assign bus_b.m0_wb_cyc_i = m_cyc;
  assign bus_a.m0_wb_stb_i = m_stb;  assign bus_b.m0_wb_stb_i = m_stb;
  assign bus_a.s_wb_dat_i  = s_dat;  assign bus_b.s_wb_dat_i  = s_dat[95:0];
  assign bus_a.s_wb_ack_i  = s_ack;  assign bus_b.s_wb_ack_i  = s_ack[2:0];

  wb_interconnect_np #(.NUM_SLAVES(4), .SEL_LSB(12), .SEL_W(2), .SLV_AW(9), .TIMEOUT(8))
    dut_a (.clk_i(clk_i), .rst(rst), .bus(bus_a));
  wb_interconnect_np #(.NUM_SLAVES(3), .SEL_LSB(12), .SEL_W(2), .SLV_AW(9), .TIMEOUT(8))
    dut_b (.clk_i(clk_i), .rst(rst), .bus(bus_b));

  // Transaction record: the forwarded request (if any), how long it has
  // waited, and a pending response (0 none, 1 ack, 2 err).
  typedef struct packed {
    logic        busy;
    logic [3:0]  idx;
    logic [31:0] dat;
    logic [8:0]  adr;
    logic [3:0]  sel;
    logic        we;
    logic [15:0] waited;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } mdl_t;

  mdl_t ma = '0;
  mdl_t mb = '0;

  function automatic mdl_t mdl_step(input mdl_t m, input int nsl, input int tmo,
                                    input logic rst_v, input logic cyc, input logic stb,
                                    input logic we, input logic [31:0] adr,
                                    input logic [31:0] dat, input logic [3:0] sel,
                                    input logic [3:0] ack, input logic [127:0] sdat);
    mdl_t n = m;
    int   k;
    if (rst_v) begin
      n = '0;
    end else if (m.resp != 2'd0) begin
      n.resp  = 2'd0;          // response shown for one cycle, nothing accepted
      n.rdata = 32'h0;
    end else if (m.busy) begin
      k = int'(m.idx);
      if (!cyc) begin
        n.busy = 1'b0;
      end else if (ack[k]) begin
        n.busy  = 1'b0;
        n.resp  = 2'd1;
        n.rdata = sdat[32*k +: 32];
      end else if (tmo > 0 && int'(m.waited) + 1 == tmo) begin
        n.busy = 1'b0;
        n.resp = 2'd2;
      end else begin
        n.waited = m.waited + 16'd1;
      end
    end else if (cyc && stb) begin
      k = int'(adr[13:12]);
      if (k < nsl) begin
        n.busy = 1'b1; n.idx = 4'(k); n.dat = dat; n.adr = adr[10:2];
        n.sel = sel; n.we = we; n.waited = 16'd0;
      end else begin
        n.resp = 2'd2;
      end
    end
    return n;
  endfunction

  // Advance both models with the inputs sampled at the active edge.
  always @(posedge clk_i) begin
    ma <= mdl_step(ma, 4, 8, rst, m_cyc, m_stb, m_we, m_adr, m_dat, m_sel, s_ack, s_dat);
    mb <= mdl_step(mb, 3, 8, rst, m_cyc, m_stb, m_we, m_adr, m_dat, m_sel, s_ack, s_dat);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(input string tag, input mdl_t m,
                         input logic [31:0] dat_o, input logic ack_o, input logic err_o,
                         input logic [31:0] sdat_o, input logic [8:0] sadr_o,
                         input logic [3:0] ssel_o, input logic swe_o,
                         input logic [3:0] scyc_o, input logic [3:0] sstb_o);
    logic [3:0] hot;
    hot = m.busy ? (4'b0001 << m.idx) : 4'b0000;
    chk({tag, "_m0_dat"}, dat_o, (m.resp == 2'd1) ? m.rdata : 32'h0);
    chk({tag, "_m0_ack"}, 32'(ack_o), 32'(m.resp == 2'd1));
    chk({tag, "_m0_err"}, 32'(err_o), 32'(m.resp == 2'd2));
    chk({tag, "_s_dat"},  sdat_o, m.busy ? m.dat : 32'h0);
    chk({tag, "_s_adr"},  32'(sadr_o), m.busy ? 32'(m.adr) : 32'h0);
    chk({tag, "_s_sel"},  32'(ssel_o), m.busy ? 32'(m.sel) : 32'h0);
    chk({tag, "_s_we"},   32'(swe_o), m.busy ? 32'(m.we) : 32'h0);
    chk({tag, "_s_cyc"},  32'(scyc_o), 32'(hot));
    chk({tag, "_s_stb"},  32'(sstb_o), 32'(hot));
  endtask

  // Every-cycle comparison of both instances against their models.
  always @(negedge clk_i) begin
    if (chk_en) begin
      cmp_dut("a", ma, bus_a.m0_wb_dat_o, bus_a.m0_wb_ack_o, bus_a.m0_wb_err_o,
              bus_a.s_wb_dat_o, bus_a.s_wb_adr_o, bus_a.s_wb_sel_o, bus_a.s_wb_we_o,
              bus_a.s_wb_cyc_o, bus_a.s_wb_stb_o);
      cmp_dut("b", mb, bus_b.m0_wb_dat_o, bus_b.m0_wb_ack_o, bus_b.m0_wb_err_o,
              bus_b.s_wb_dat_o, bus_b.s_wb_adr_o, bus_b.s_wb_sel_o, bus_b.s_wb_we_o,
              {1'b0, bus_b.s_wb_cyc_o}, {1'b0, bus_b.s_wb_stb_o});
    end
  end

  task automatic nxt();
    @(posedge clk_i);
    #1;
  endtask

  task automatic mreq(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                      input logic [3:0] sel);
    m_cyc = 1'b1; m_stb = 1'b1; m_adr = adr; m_we = we; m_dat = dat; m_sel = sel;
  endtask

  task automatic midle();
    m_cyc = 1'b0; m_stb = 1'b0; m_adr = 32'h0; m_we = 1'b0; m_dat = 32'h0; m_sel = 4'h0;
  endtask

  initial begin
    // reset
    midle();
    nxt();
    chk_en = 1'b1;
    nxt();
    chk("rst_ack", 32'(bus_a.m0_wb_ack_o), 32'h0);
    chk("rst_cyc", 32'(bus_a.s_wb_cyc_o), 32'h0);
    rst = 1'b0;
    nxt();

    // write to slave 1, acked two cycles after its stb
    mreq(32'h0000_1010, 1'b1, 32'hA5A5_1234, 4'hF);
    nxt();
    chk("wr_s_adr", 32'(bus_a.s_wb_adr_o), 32'h004);
    chk("wr_s_stb", 32'(bus_a.s_wb_stb_o), 32'h2);
    chk("wr_s_dat", bus_a.s_wb_dat_o, 32'hA5A5_1234);
    chk("wr_s_we",  32'(bus_a.s_wb_we_o), 32'h1);
    chk("mdl_adr",  32'(ma.adr), 32'h004);
    chk("mdl_busy", 32'(ma.busy), 32'h1);
    nxt();
    chk("wr_ack_early", 32'(bus_a.m0_wb_ack_o), 32'h0);
    s_ack = 4'b0010;
    nxt();
    chk("wr_ack", 32'(bus_a.m0_wb_ack_o), 32'h1);
    chk("wr_err", 32'(bus_a.m0_wb_err_o), 32'h0);
    chk("wr_stb_drop", 32'(bus_a.s_wb_stb_o), 32'h0);
    midle(); s_ack = 4'b0000;
    nxt();
    chk("wr_ack_pulse", 32'(bus_a.m0_wb_ack_o), 32'h0);

    // zero-wait read from slave 3; unmapped on the 3-slave instance
    mreq(32'h0000_3000, 1'b0, 32'h0, 4'hF);
    s_ack = 4'b1000; s_dat[127:96] = 32'hCAFE_F00D;
    nxt();
    chk("rd_ack_early", 32'(bus_a.m0_wb_ack_o), 32'h0);
    chk("rd_s_stb", 32'(bus_a.s_wb_stb_o), 32'h8);
    chk("um_err", 32'(bus_b.m0_wb_err_o), 32'h1);
    chk("um_cyc", 32'(bus_b.s_wb_cyc_o), 32'h0);
    chk("mdl_b_err", 32'(mb.resp), 32'h2);
    nxt();
    chk("rd_ack", 32'(bus_a.m0_wb_ack_o), 32'h1);
    chk("rd_dat", bus_a.m0_wb_dat_o, 32'hCAFE_F00D);
    chk("mdl_rdata", ma.rdata, 32'hCAFE_F00D);
    chk("um_err_pulse", 32'(bus_b.m0_wb_err_o), 32'h0);
    chk("um_cyc2", 32'(bus_b.s_wb_cyc_o), 32'h0);
    midle(); s_ack = 4'b0000;
    nxt();
    chk("rd_ack_pulse", 32'(bus_a.m0_wb_ack_o), 32'h0);
    chk("rd_dat_clr", bus_a.m0_wb_dat_o, 32'h0);

    // slave 2 never acks: timeout after 8 REQ cycles
    mreq(32'h0000_2000, 1'b0, 32'h0, 4'h3);
    nxt();
    repeat (7) nxt();
    chk("to_stb_held", 32'(bus_a.s_wb_stb_o), 32'h4);
    chk("to_err_early", 32'(bus_a.m0_wb_err_o), 32'h0);
    nxt();
    chk("to_err", 32'(bus_a.m0_wb_err_o), 32'h1);
    chk("to_ack", 32'(bus_a.m0_wb_ack_o), 32'h0);
    chk("to_stb_drop", 32'(bus_a.s_wb_stb_o), 32'h0);
    midle();
    nxt();
    chk("to_err_pulse", 32'(bus_a.m0_wb_err_o), 32'h0);

    // master abort in REQ, then a normal read
    mreq(32'h0000_0000, 1'b1, 32'h5555_AAAA, 4'h1);
    nxt();
    nxt();
    chk("ab_stb", 32'(bus_a.s_wb_stb_o), 32'h1);
    midle();
    nxt();
    chk("ab_cyc_drop", 32'(bus_a.s_wb_cyc_o), 32'h0);
    chk("ab_ack", 32'(bus_a.m0_wb_ack_o), 32'h0);
    chk("ab_err", 32'(bus_a.m0_wb_err_o), 32'h0);
    nxt();
    chk("ab_err2", 32'(bus_a.m0_wb_err_o), 32'h0);
    mreq(32'h0000_0004, 1'b0, 32'h0, 4'hF);
    s_ack = 4'b0001; s_dat[31:0] = 32'h1234_5678;
    nxt();
    chk("ab2_adr", 32'(bus_a.s_wb_adr_o), 32'h001);
    nxt();
    chk("ab2_ack", 32'(bus_a.m0_wb_ack_o), 32'h1);
    chk("ab2_dat", bus_a.m0_wb_dat_o, 32'h1234_5678);
    midle(); s_ack = 4'b0000;
    nxt();

    // reset in REQ, then a read with a stray ack on slave 1
    mreq(32'h0000_0000, 1'b1, 32'hFFFF_0000, 4'hF);
    nxt();
    rst = 1'b1; midle();
    nxt();
    chk("rs_cyc", 32'(bus_a.s_wb_cyc_o), 32'h0);
    chk("rs_dat", bus_a.s_wb_dat_o, 32'h0);
    chk("rs_ack", 32'(bus_a.m0_wb_ack_o), 32'h0);
    chk("rs_err", 32'(bus_a.m0_wb_err_o), 32'h0);
    nxt();
    rst = 1'b0;
    mreq(32'h0000_0008, 1'b0, 32'h0, 4'hF);
    s_ack = 4'b0010; s_dat[31:0] = 32'h0BAD_BEEF; s_dat[63:32] = 32'hFFFF_FFFF;
    nxt();
    chk("rs2_stb", 32'(bus_a.s_wb_stb_o), 32'h1);
    nxt();
    chk("stray_ack", 32'(bus_a.m0_wb_ack_o), 32'h0);
    chk("stray_stb", 32'(bus_a.s_wb_stb_o), 32'h1);
    s_ack = 4'b0011;
    nxt();
    chk("rs2_ack", 32'(bus_a.m0_wb_ack_o), 32'h1);
    chk("rs2_dat", bus_a.m0_wb_dat_o, 32'h0BAD_BEEF);
    midle(); s_ack = 4'b0000;
    nxt();

    // randomized traffic, with quiet stretches that force timeouts
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        m_adr = $urandom();
        m_dat = $urandom();
        m_sel = 4'($urandom_range(0, 15));
        m_we  = 1'($urandom_range(0, 1));
      end
      m_cyc = ($urandom_range(0, 7) != 0);
      m_stb = m_cyc && ($urandom_range(0, 7) != 0);
      if ((c / 300) % 3 == 2) begin
        s_ack = 4'b0000;
      end else begin
        for (int k = 0; k < 4; k++) s_ack[k] = ($urandom_range(0, 3) == 0);
      end
      s_dat = {$urandom(), $urandom(), $urandom(), $urandom()};
      rst = ($urandom_range(0, 249) == 0);
      nxt();
    end
    rst = 1'b0; midle(); s_ack = 4'b0000;
    nxt();
    nxt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_interconnect_np.md
Name: wb_interconnect_np

Overview:
- Parametrised single-master, N-slave Wishbone classic interconnect. Successor to the fixed 4-slave crossbar in the user area.
- Registers the master request, decodes the slave index from an address field, and holds the request until that slave acks.
- Returns a registered ack/data to the master. Adds an error response for unmapped slaves and for bus timeouts.
- Sits between the caravel Wishbone port (M0) and the SRAM/UART/TRNG/SPI peripherals.

Parameters:
- NUM_SLAVES, 4, number of slave ports (1..16).
- SEL_LSB, 12, LSB of the slave-select field in m0_wb_adr_i.
- SEL_W, 2, width of the slave-select field; must satisfy 2**SEL_W >= NUM_SLAVES.
- SLV_AW, 9, slave word-address width.
- TIMEOUT, 255, max cycles waiting for a slave ack; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst  in  1  synchronous reset, active-high
- m0_wb_dat_i  in  32  master write data
- m0_wb_adr_i  in  32  master byte address
- m0_wb_sel_i  in  4  byte selects
- m0_wb_we_i  in  1  write enable
- m0_wb_cyc_i  in  1  cycle
- m0_wb_stb_i  in  1  strobe
- m0_wb_dat_o  out  32  registered read data
- m0_wb_ack_o  out  1  registered ack
- m0_wb_err_o  out  1  registered error (unmapped slave or timeout)
- s_wb_dat_i  in  32*NUM_SLAVES  slave read data, slave k at bits [32k+31:32k]
- s_wb_ack_i  in  NUM_SLAVES  slave acks
- s_wb_dat_o  out  32  write data broadcast to all slaves
- s_wb_adr_o  out  SLV_AW  word address, = m0_wb_adr_i[SLV_AW+1:2]
- s_wb_sel_o  out  4  byte selects, broadcast
- s_wb_we_o  out  1  write enable, broadcast
- s_wb_cyc_o  out  NUM_SLAVES  one-hot per-slave cyc
- s_wb_stb_o  out  NUM_SLAVES  one-hot per-slave stb

Behaviour:
- Reset:
  - All outputs 0; state IDLE; timeout counter 0.
  - Reset mid-transaction drops all slave cyc/stb on the next edge. No ack or err is issued.
- States: IDLE, REQ, RESP.
- IDLE:
  - On m0_wb_cyc_i & m0_wb_stb_i, latch dat/adr/sel/we and idx = m0_wb_adr_i[SEL_LSB+SEL_W-1:SEL_LSB].
  - If idx < NUM_SLAVES: go to REQ. s_wb_cyc_o[idx] and s_wb_stb_o[idx] go high on the next cycle.
  - Otherwise: go to RESP with err=1, dat=0. No slave is touched.
- REQ:
  - Request outputs are held stable.
  - Only s_wb_ack_i[idx] is observed; acks from non-selected slaves are ignored.
  - On ack: capture s_wb_dat_i[idx] into m0_wb_dat_o, set ack=1, drop slave cyc/stb, go to RESP.
  - Timeout counter increments each REQ cycle. When it reaches TIMEOUT (TIMEOUT>0) without an ack: err=1, dat=0, drop slave cyc/stb, go to RESP.
  - An ack arriving in the same cycle as the terminal count wins: ack=1, err=0.
  - If m0_wb_cyc_i drops (master abort): drop slave cyc/stb, go to IDLE with no ack/err. Counter clears.
- RESP:
  - ack or err is high for exactly one cycle, then return to IDLE.
  - No new request is accepted in RESP.
  - A request still present in IDLE afterwards is treated as a new transaction.
- Latency:
  - Master stb sampled at edge N → slave stb visible in cycle N+1.
  - Slave ack sampled at edge M → master ack visible in cycle M+1.
  - Minimum round trip is 3 cycles with a zero-wait slave.
- Signals outside REQ:
  - s_wb_dat_o/adr_o/sel_o/we_o are 0.
  - m0_wb_dat_o returns to 0 after RESP.
- Master ack and err are never asserted together.
- At most one transaction is outstanding.

Test Plan:
- Write 0xA5A5_1234 to 0x0000_1010 with sel=0xF. Slave 1 acks 2 cycles later → s_wb_adr_o=0x004, s_wb_stb_o=4'b0010; m0 ack pulses 1 cycle after the slave ack.
- Read 0x0000_3000, slave 3 returns 0xCAFEF00D with a zero-wait ack → m0_wb_dat_o=0xCAFEF00D alongside a 1-cycle ack; 3-cycle round trip.
- NUM_SLAVES=3, access 0x0000_3000 → m0_wb_err_o pulses after 2 cycles; no s_wb_cyc_o bit asserts.
- TIMEOUT=8, slave 2 never acks → err pulses once after 8 REQ cycles; slave stb drops on the same edge.
- Master drops cyc during REQ → slave cyc/stb drop next cycle; no ack/err; the next transaction completes normally.
- rst asserted in REQ, then a read to slave 0 → all outputs 0 during reset; the following read acks correctly and a stray ack on slave 1 is ignored.
